// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: control-flow opcodes, PC-unit state encoding and
// the condition-code derivation used by every register-file write path.
package lc3_pkg;

   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_JSR  = 4'b0100;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   typedef enum logic {
      RUN       = 1'b0,
      TRAP_WAIT = 1'b1
   } pc_state_e;

   // Exactly one of {n,z,p} is set for any 16-bit value.
   function automatic logic [2:0] nzp_from(input logic [15:0] value);
      logic n;
      logic z;
      n = value[15];
      z = (value == 16'h0000);
      return {n, z, ~n & ~z};
   endfunction

endpackage

// File: rtl/lc3_nzp_reg.sv
// NZP condition-code register. Loads the codes of the written value on every
// register-file write, independent of the control-flow state.
module lc3_nzp_reg
   import lc3_pkg::*;
#(
   parameter logic [2:0] CC_RESET = 3'b010
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_we,
   input  logic [15:0] i_value,
   output logic [2:0]  o_nzp
);

   logic [2:0] r_nzp;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_nzp <= CC_RESET;
      end else if (i_we) begin
         r_nzp <= nzp_from(i_value);
      end
   end

   assign o_nzp = r_nzp;

endmodule

// File: rtl/lc3_pc_unit.sv
// LC-3 program counter and control-flow unit: resolves BR, JMP/RET, JSR/JSRR
// and TRAP, and runs the trap-vector read handshake with memory.
module lc3_pc_unit
   import lc3_pkg::*;
#(
   parameter int              ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(16'h3000),
   parameter logic [2:0]      CC_RESET = 3'b010
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   input  logic [15:0]       instr,
   output logic              instr_ready,
   input  logic [ADDR_W-1:0] base_reg,
   input  logic              cc_we,
   input  logic [15:0]       cc_value,
   output logic [ADDR_W-1:0] pc,
   output logic [2:0]        nzp,
   output logic              link_we,
   output logic [ADDR_W-1:0] link_data,
   output logic              vec_req,
   output logic [ADDR_W-1:0] vec_addr,
   input  logic              vec_ack,
   input  logic [ADDR_W-1:0] vec_data,
   output logic              taken
);

   pc_state_e         r_state;
   logic [ADDR_W-1:0] r_pc;
   logic              r_taken;
   logic              r_link_we;
   logic [ADDR_W-1:0] r_link_data;
   logic              r_vec_req;
   logic [ADDR_W-1:0] r_vec_addr;

   pc_state_e         w_state_next;
   logic [ADDR_W-1:0] w_pc_next;
   logic              w_taken_next;
   logic              w_link_we_next;
   logic [ADDR_W-1:0] w_link_data_next;
   logic              w_vec_req_next;
   logic [ADDR_W-1:0] w_vec_addr_next;

   logic [2:0]        w_nzp;
   logic [ADDR_W-1:0] w_inc;
   logic [ADDR_W-1:0] w_br_target;
   logic [ADDR_W-1:0] w_jsr_target;
   logic [ADDR_W-1:0] w_trap_vec;
   logic              w_br_cond;
   logic [3:0]        w_opcode;

   // BR sees the registered codes; a same-cycle cc_we lands after this edge.
   lc3_nzp_reg #(
      .CC_RESET (CC_RESET)
   ) u_nzp_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (cc_we),
      .i_value (cc_value),
      .o_nzp   (w_nzp)
   );

   assign w_opcode     = instr[15:12];
   assign w_inc        = r_pc + ADDR_W'(1);
   assign w_br_target  = w_inc + {{(ADDR_W-9){instr[8]}}, instr[8:0]};
   assign w_jsr_target = w_inc + {{(ADDR_W-11){instr[10]}}, instr[10:0]};
   assign w_trap_vec   = {{(ADDR_W-8){1'b0}}, instr[7:0]};
   assign w_br_cond    = (instr[11] & w_nzp[2]) | (instr[10] & w_nzp[1]) |
                         (instr[9]  & w_nzp[0]);

   // NOTE: every variable gets a default before the case so no path leaves a
   // value unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_next     = r_state;
      w_pc_next        = r_pc;
      w_taken_next     = 1'b0;
      w_link_we_next   = 1'b0;
      w_link_data_next = r_link_data;
      w_vec_req_next   = r_vec_req;
      w_vec_addr_next  = r_vec_addr;

      case (r_state)
         RUN: begin
            if (instr_valid) begin
               w_pc_next = w_inc;
               case (w_opcode)
                  OP_BR: begin
                     if (w_br_cond) begin
                        w_pc_next    = w_br_target;
                        w_taken_next = 1'b1;
                     end
                  end
                  OP_JMP: begin
                     w_pc_next    = base_reg;
                     w_taken_next = 1'b1;
                  end
                  OP_JSR: begin
                     w_pc_next        = instr[11] ? w_jsr_target : base_reg;
                     w_taken_next     = 1'b1;
                     w_link_we_next   = 1'b1;
                     w_link_data_next = w_inc;
                  end
                  OP_TRAP: begin
                     w_pc_next        = r_pc;
                     w_link_we_next   = 1'b1;
                     w_link_data_next = w_inc;
                     w_vec_req_next   = 1'b1;
                     w_vec_addr_next  = w_trap_vec;
                     w_state_next     = TRAP_WAIT;
                  end
                  default: ;
               endcase
            end
         end
         TRAP_WAIT: begin
            if (vec_ack) begin
               w_pc_next      = vec_data;
               w_taken_next   = 1'b1;
               w_vec_req_next = 1'b0;
               w_state_next   = RUN;
            end
         end
         default: w_state_next = RUN;
      endcase
   end

   // An asynchronous reset in TRAP_WAIT drops the request, so a late ack is
   // seen in RUN and ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= RUN;
         r_pc        <= RESET_PC;
         r_taken     <= 1'b0;
         r_link_we   <= 1'b0;
         r_link_data <= '0;
         r_vec_req   <= 1'b0;
         r_vec_addr  <= '0;
      end else begin
         r_state     <= w_state_next;
         r_pc        <= w_pc_next;
         r_taken     <= w_taken_next;
         r_link_we   <= w_link_we_next;
         r_link_data <= w_link_data_next;
         r_vec_req   <= w_vec_req_next;
         r_vec_addr  <= w_vec_addr_next;
      end
   end

   assign instr_ready = (r_state == RUN);
   assign pc          = r_pc;
   assign nzp         = w_nzp;
   assign link_we     = r_link_we;
   assign link_data   = r_link_data;
   assign vec_req     = r_vec_req;
   assign vec_addr    = r_vec_addr;
   assign taken       = r_taken;

endmodule

// File: tb/tb_lc3_pc_unit.sv
// Bench for lc3_pc_unit: directed vector table, trap/reset sequences, then
// random traffic against a reference model written from the ISA rules.
module tb_lc3_pc_unit;

   localparam int ADDR_W = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              instr_valid;
   logic [15:0]       instr;
   logic              instr_ready;
   logic [ADDR_W-1:0] base_reg;
   logic              cc_we;
   logic [15:0]       cc_value;
   logic [ADDR_W-1:0] pc;
   logic [2:0]        nzp;
   logic              link_we;
   logic [ADDR_W-1:0] link_data;
   logic              vec_req;
   logic [ADDR_W-1:0] vec_addr;
   logic              vec_ack;
   logic [ADDR_W-1:0] vec_data;
   logic              taken;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lc3_pc_unit #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (16'h3000),
      .CC_RESET (3'b010)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .base_reg    (base_reg),
      .cc_we       (cc_we),
      .cc_value    (cc_value),
      .pc          (pc),
      .nzp         (nzp),
      .link_we     (link_we),
      .link_data   (link_data),
      .vec_req     (vec_req),
      .vec_addr    (vec_addr),
      .vec_ack     (vec_ack),
      .vec_data    (vec_data),
      .taken       (taken)
   );

   typedef struct {
      logic        valid;
      logic [15:0] ins;
      logic [15:0] base;
      logic        we;
      logic [15:0] val;
      logic [15:0] e_pc;
      logic [2:0]  e_nzp;
      logic        e_taken;
      logic        e_link_we;
      logic [15:0] e_link_data;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] base,
                        input logic we, input logic [15:0] val);
      instr_valid = v;
      instr       = ins;
      base_reg    = base;
      cc_we       = we;
      cc_value    = val;
   endtask

   function automatic logic [2:0] ref_nzp(input logic [15:0] v);
      if (v == 16'h0000) return 3'b010;
      if (v >= 16'h8000) return 3'b100;
      return 3'b001;
   endfunction

   function automatic int sx(input int v, input int bits);
      return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
   endfunction

   // Reference model state.
   int         m_pc;
   logic [2:0] m_nzp;
   bit         m_trap;
   int         m_vec_addr;
   int         m_link;
   bit         e_taken;
   bit         e_link_we;

   initial begin
      // {valid, instr, base, cc_we, cc_value, pc, nzp, taken, link_we, link_data}
      vecs[0]  = '{1'b1, 16'h0405, 16'h0000, 1'b0, 16'h0000, 16'h3006, 3'b010, 1'b1, 1'b0, 16'h0};    // BRz +5
      vecs[1]  = '{1'b1, 16'hC1C0, 16'h3000, 1'b1, 16'h8000, 16'h3000, 3'b100, 1'b1, 1'b0, 16'h0};    // JMP + cc
      vecs[2]  = '{1'b1, 16'h03FE, 16'h0000, 1'b0, 16'h0000, 16'h3001, 3'b100, 1'b0, 1'b0, 16'h0};    // BRp -2 nt
      vecs[3]  = '{1'b1, 16'h0203, 16'h0000, 1'b1, 16'h0001, 16'h3002, 3'b001, 1'b0, 1'b0, 16'h0};    // old nzp
      vecs[4]  = '{1'b1, 16'h0203, 16'h0000, 1'b0, 16'h0000, 16'h3006, 3'b001, 1'b1, 1'b0, 16'h0};    // BRp +3
      vecs[5]  = '{1'b1, 16'hC000, 16'h3000, 1'b0, 16'h0000, 16'h3000, 3'b001, 1'b1, 1'b0, 16'h0};    // JMP
      vecs[6]  = '{1'b1, 16'h4810, 16'h0000, 1'b0, 16'h0000, 16'h3011, 3'b001, 1'b1, 1'b1, 16'h3001}; // JSR
      vecs[7]  = '{1'b1, 16'hC1C0, 16'h3001, 1'b0, 16'h0000, 16'h3001, 3'b001, 1'b1, 1'b0, 16'h0};    // RET
      vecs[8]  = '{1'b1, 16'h0005, 16'h0000, 1'b0, 16'h0000, 16'h3002, 3'b001, 1'b0, 1'b0, 16'h0};    // BR 000
      vecs[9]  = '{1'b1, 16'h0FFD, 16'h0000, 1'b0, 16'h0000, 16'h3000, 3'b001, 1'b1, 1'b0, 16'h0};    // BRnzp -3
      vecs[10] = '{1'b1, 16'h40C0, 16'h4000, 1'b0, 16'h0000, 16'h4000, 3'b001, 1'b1, 1'b1, 16'h3001}; // JSRR
      vecs[11] = '{1'b1, 16'h1021, 16'h0000, 1'b0, 16'h0000, 16'h4001, 3'b001, 1'b0, 1'b0, 16'h0};    // ADD
      vecs[12] = '{1'b0, 16'hC000, 16'h1234, 1'b0, 16'h0000, 16'h4001, 3'b001, 1'b0, 1'b0, 16'h0};    // idle
      vecs[13] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h4001, 3'b010, 1'b0, 1'b0, 16'h0};    // cc zero
      vecs[14] = '{1'b1, 16'hC000, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF, 3'b010, 1'b1, 1'b0, 16'h0};    // JMP FFFF
      vecs[15] = '{1'b1, 16'h1021, 16'h0000, 1'b0, 16'h0000, 16'h0000, 3'b010, 1'b0, 1'b0, 16'h0};    // wrap inc
      vecs[16] = '{1'b1, 16'hC000, 16'hFFFE, 1'b0, 16'h0000, 16'hFFFE, 3'b010, 1'b1, 1'b0, 16'h0};    // JMP FFFE
      vecs[17] = '{1'b1, 16'h0405, 16'h0000, 1'b0, 16'h0000, 16'h0004, 3'b010, 1'b1, 1'b0, 16'h0};    // wrap BR

      rst_n    = 1'b0;
      vec_ack  = 1'b0;
      vec_data = '0;
      drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      check("rst_pc", 32'(pc), 32'h3000);
      check("rst_nzp", 32'(nzp), 32'b010);
      check("rst_ready", 32'(instr_ready), 32'd1);
      check("rst_taken", 32'(taken), 32'd0);
      check("rst_link_we", 32'(link_we), 32'd0);
      check("rst_link_data", 32'(link_data), 32'h0);
      check("rst_vec_req", 32'(vec_req), 32'd0);
      check("rst_vec_addr", 32'(vec_addr), 32'h0);

      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].valid, vecs[i].ins, vecs[i].base, vecs[i].we, vecs[i].val);
         step();
         check($sformatf("vec%0d_pc", i), 32'(pc), 32'(vecs[i].e_pc));
         check($sformatf("vec%0d_nzp", i), 32'(nzp), 32'(vecs[i].e_nzp));
         check($sformatf("vec%0d_taken", i), 32'(taken), 32'(vecs[i].e_taken));
         check($sformatf("vec%0d_link_we", i), 32'(link_we), 32'(vecs[i].e_link_we));
         if (vecs[i].e_link_we)
            check($sformatf("vec%0d_link_data", i), 32'(link_data), 32'(vecs[i].e_link_data));
         check($sformatf("vec%0d_ready", i), 32'(instr_ready), 32'd1);
      end

      // vec_ack while in RUN has no effect.
      drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
      vec_ack  = 1'b1;
      vec_data = 16'h1234;
      step();
      check("run_ack_pc", 32'(pc), 32'h0004);
      check("run_ack_taken", 32'(taken), 32'd0);
      vec_ack = 1'b0;

      drive(1'b1, 16'hC000, 16'h3004, 1'b0, 16'h0);
      step();
      check("pre_trap_pc", 32'(pc), 32'h3004);

      // TRAP x25 with three wait cycles, then the vector read completes.
      drive(1'b1, 16'hF025, 16'h0, 1'b0, 16'h0);
      step();
      check("trap_link_we", 32'(link_we), 32'd1);
      check("trap_link_data", 32'(link_data), 32'h3005);
      check("trap_vec_req", 32'(vec_req), 32'd1);
      check("trap_vec_addr", 32'(vec_addr), 32'h0025);
      check("trap_pc_hold", 32'(pc), 32'h3004);
      check("trap_taken", 32'(taken), 32'd0);
      for (int w = 0; w < 3; w++) begin
         check($sformatf("wait%0d_ready", w), 32'(instr_ready), 32'd0);
         drive(1'b1, 16'hC000, 16'h7777, (w == 1), 16'h8000);
         step();
         check($sformatf("wait%0d_vec_req", w), 32'(vec_req), 32'd1);
         check($sformatf("wait%0d_vec_addr", w), 32'(vec_addr), 32'h0025);
         check($sformatf("wait%0d_pc", w), 32'(pc), 32'h3004);
         check($sformatf("wait%0d_link_we", w), 32'(link_we), 32'd0);
      end
      check("wait_nzp_update", 32'(nzp), 32'b100);
      check("wait_ready_last", 32'(instr_ready), 32'd0);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
      vec_ack  = 1'b1;
      vec_data = 16'h0520;
      step();
      vec_ack = 1'b0;
      check("ack_pc", 32'(pc), 32'h0520);
      check("ack_taken", 32'(taken), 32'd1);
      check("ack_vec_req", 32'(vec_req), 32'd0);
      check("ack_ready", 32'(instr_ready), 32'd1);
      step();
      check("ack_taken_pulse", 32'(taken), 32'd0);

      // TRAP x23 aborted by reset; a late ack must not move the PC.
      drive(1'b1, 16'hF023, 16'h0, 1'b0, 16'h0);
      step();
      check("trap23_vec_req", 32'(vec_req), 32'd1);
      check("trap23_vec_addr", 32'(vec_addr), 32'h0023);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_pc", 32'(pc), 32'h3000);
      check("abort_vec_req", 32'(vec_req), 32'd0);
      check("abort_nzp", 32'(nzp), 32'b010);
      #1;
      rst_n    = 1'b1;
      vec_ack  = 1'b1;
      vec_data = 16'h0520;
      step();
      vec_ack = 1'b0;
      check("late_ack_pc", 32'(pc), 32'h3000);
      check("late_ack_taken", 32'(taken), 32'd0);
      check("late_ack_ready", 32'(instr_ready), 32'd1);

      // Random traffic against the reference model.
      m_pc       = 'h3000;
      m_nzp      = 3'b010;
      m_trap     = 1'b0;
      m_vec_addr = 0;
      m_link     = 0;
      for (int k = 0; k < 400; k++) begin
         int nxt;
         bit take;
         drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
               $urandom_range(0, 2) == 0,
               ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom));
         vec_ack  = ($urandom_range(0, 2) == 0);
         vec_data = 16'($urandom);

         e_taken   = 1'b0;
         e_link_we = 1'b0;
         nxt       = (m_pc + 1) % 65536;
         if (m_trap) begin
            if (vec_ack) begin
               m_pc    = int'(vec_data);
               e_taken = 1'b1;
               m_trap  = 1'b0;
            end
         end else if (instr_valid) begin
            case (int'(instr[15:12]))
               0: begin
                  take = (instr[11] && m_nzp[2]) || (instr[10] && m_nzp[1]) ||
                         (instr[9] && m_nzp[0]);
                  m_pc    = take ? ((nxt + sx(int'(instr[8:0]), 9)) & 'hFFFF) : nxt;
                  e_taken = take;
               end
               12: begin
                  m_pc    = int'(base_reg);
                  e_taken = 1'b1;
               end
               4: begin
                  m_pc      = instr[11] ? ((nxt + sx(int'(instr[10:0]), 11)) & 'hFFFF)
                                        : int'(base_reg);
                  e_taken   = 1'b1;
                  e_link_we = 1'b1;
                  m_link    = nxt;
               end
               15: begin
                  e_link_we  = 1'b1;
                  m_link     = nxt;
                  m_vec_addr = int'(instr[7:0]);
                  m_trap     = 1'b1;
               end
               default: m_pc = nxt;
            endcase
         end
         if (cc_we) m_nzp = ref_nzp(cc_value);

         step();
         check("rnd_pc", 32'(pc), 32'(m_pc));
         check("rnd_nzp", 32'(nzp), 32'(m_nzp));
         check("rnd_taken", 32'(taken), 32'(e_taken));
         check("rnd_link_we", 32'(link_we), 32'(e_link_we));
         if (e_link_we) check("rnd_link_data", 32'(link_data), 32'(m_link));
         check("rnd_vec_req", 32'(vec_req), 32'(m_trap));
         if (m_trap) check("rnd_vec_addr", 32'(vec_addr), 32'(m_vec_addr));
         check("rnd_ready", 32'(instr_ready), 32'(!m_trap));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
